// File: rtl/qar_gpio_ctrl.sv
// qar_gpio_ctrl -- memory-mapped GPIO block with synchronised inputs,
// optional per-pin debounce, and edge/level interrupt capture.
//
// Ports:
//   clk, rst_n             single clock, asynchronous active-low reset
//   bus_valid, bus_we      access request / write strobe (zero wait states)
//   bus_addr[7:0]          byte offset, bits [1:0] ignored
//   bus_wdata[31:0]        write data
//   bus_ready              equals bus_valid
//   bus_rdata[31:0]        combinational read data
//   gpio_in[WIDTH-1:0]     asynchronous pin inputs
//   gpio_out, gpio_dir     OUT and DIR registers (1 = output)
//   gpio_irq               registered |(STATUS & IRQ_EN)
//
// Register map (word offsets): 0x00 IN, 0x04 OUT, 0x08 DIR, 0x0C IRQ_EN,
// 0x10 IRQ_TYPE, 0x14 IRQ_POL, 0x18 IRQ_STATUS (W1C), 0x1C OUT_SET,
// 0x20 OUT_CLR, 0x24 DB_LIMIT.
//
// Build option: define QAR_GPIO_DEBOUNCE_EN to add the DB_LIMIT register and
// per-pin debounce counters. Without it the filtered pin is the synchronised
// pin and 0x24 reads as zero.
module qar_gpio_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [7:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic             bus_ready,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_dir,
  output logic             gpio_irq
);

  localparam logic [5:0] A_IN     = 6'd0;
  localparam logic [5:0] A_OUT    = 6'd1;
  localparam logic [5:0] A_DIR    = 6'd2;
  localparam logic [5:0] A_EN     = 6'd3;
  localparam logic [5:0] A_TYPE   = 6'd4;
  localparam logic [5:0] A_POL    = 6'd5;
  localparam logic [5:0] A_STATUS = 6'd6;
  localparam logic [5:0] A_SET    = 6'd7;
  localparam logic [5:0] A_CLR    = 6'd8;
  localparam logic [5:0] A_DB     = 6'd9;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] out_r, dir_r, en_r, type_r, pol_r, status_r, prev_r;
  logic [WIDTH-1:0] wdata_s, w1c_s, edge_hit_s, lvl_hit_s, status_nxt_s;
  logic [5:0]       word_s;
  logic             wr_en_s;
  logic             irq_r;
  logic [31:0]      rd_s;
  logic             unused_bits;

  assign word_s      = bus_addr[7:2];
  assign wr_en_s     = bus_valid & bus_we;
  assign wdata_s     = bus_wdata[WIDTH-1:0];
  assign sync_s      = sync_r[SYNC_STAGES-1];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  assign bus_ready = bus_valid;
  assign bus_rdata = rd_s;
  assign gpio_out  = out_r;
  assign gpio_dir  = dir_r;
  assign gpio_irq  = irq_r;

  // Input synchroniser chain; stage 0 samples the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], gpio_in};
    end
  end

`ifdef QAR_GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0]            db_limit_r;
  logic [WIDTH-1:0][DB_CNT_W-1:0] db_cnt_r;
  logic [WIDTH-1:0]               filt_r;

  assign filt_s = filt_r;

  // Debounce limit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_limit_r <= '0;
    end else if (wr_en_s && (word_s == A_DB)) begin
      db_limit_r <= bus_wdata[DB_CNT_W-1:0];
    end
  end

  // Per-pin filter: the filtered value flips only once the synchronised
  // value has differed for DB_LIMIT+1 consecutive cycles; any agreement
  // restarts the count. The >= keeps a lowered limit from stalling a count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r   <= '0;
      db_cnt_r <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_s[i] != filt_r[i]) begin
          if (db_cnt_r[i] >= db_limit_r) begin
            filt_r[i]   <= sync_s[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end
`else
  assign filt_s = sync_s;
`endif

  // Software-visible control registers, including atomic set/clear of OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= '0;
      dir_r  <= '0;
      en_r   <= '0;
      type_r <= '0;
      pol_r  <= '0;
    end else if (wr_en_s) begin
      case (word_s)
        A_OUT:   out_r  <= wdata_s;
        A_DIR:   dir_r  <= wdata_s;
        A_EN:    en_r   <= wdata_s;
        A_TYPE:  type_r <= wdata_s;
        A_POL:   pol_r  <= wdata_s;
        A_SET:   out_r  <= out_r | wdata_s;
        A_CLR:   out_r  <= out_r & ~wdata_s;
        default: begin end
      endcase
    end
  end

  // Next STATUS: edge bits are sticky and a fresh edge beats a same-cycle
  // W1C; level bits simply mirror the pin at the selected level.
  always_comb begin
    w1c_s = '0;
    if (wr_en_s && (word_s == A_STATUS)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = '0;
    end
    edge_hit_s   = (pol_r & filt_s & ~prev_r) | (~pol_r & ~filt_s & prev_r);
    lvl_hit_s    = (pol_r & filt_s) | (~pol_r & ~filt_s);
    status_nxt_s = (type_r & (edge_hit_s | (status_r & ~w1c_s)))
                 | (~type_r & lvl_hit_s);
  end

  // Status, edge history and the registered interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r <= '0;
      prev_r   <= '0;
      irq_r    <= 1'b0;
    end else begin
      status_r <= status_nxt_s;
      prev_r   <= filt_s;
      irq_r    <= |(status_r & en_r);
    end
  end

  // Read mux; narrow registers are zero-extended, WO/unmapped read zero.
  always_comb begin
    rd_s = 32'd0;
    case (word_s)
      A_IN:     rd_s[WIDTH-1:0] = sync_s;
      A_OUT:    rd_s[WIDTH-1:0] = out_r;
      A_DIR:    rd_s[WIDTH-1:0] = dir_r;
      A_EN:     rd_s[WIDTH-1:0] = en_r;
      A_TYPE:   rd_s[WIDTH-1:0] = type_r;
      A_POL:    rd_s[WIDTH-1:0] = pol_r;
      A_STATUS: rd_s[WIDTH-1:0] = status_r;
`ifdef QAR_GPIO_DEBOUNCE_EN
      A_DB:     rd_s[DB_CNT_W-1:0] = db_limit_r;
`endif
      default:  rd_s = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_qar_gpio_ctrl.sv
// Directed self-checking bench for qar_gpio_ctrl (default parameters).
module tb_qar_gpio_ctrl;

`ifdef QAR_GPIO_DEBOUNCE_EN
  localparam int DB_LAT = 1;
`else
  localparam int DB_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid, bus_we, bus_ready, gpio_irq;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [31:0] gpio_in, gpio_out, gpio_dir;
  logic [31:0] rd;
  int          checks = 0;
  int          failures = 0;
  int          irq_rises = 0;
  int          base_rises;
  logic        irq_d = 1'b0;

  qar_gpio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .gpio_irq(gpio_irq)
  );

  always #5 clk = ~clk;

  // Count rising transitions of gpio_irq, sampled mid-cycle.
  always @(negedge clk) begin
    irq_d <= gpio_irq;
    if (gpio_irq && !irq_d) irq_rises <= irq_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1;
    d = bus_rdata;
    bus_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    peek(a, d);
  endtask

  initial begin
    rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = 8'h00;
    bus_wdata = 32'h0; gpio_in = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", gpio_out, 32'h0);
    check("rst_dir", gpio_dir, 32'h0);
    check("rst_irq", {31'h0, gpio_irq}, 32'h0);
    check("ready_idle", {31'h0, bus_ready}, 32'h0);
    for (int a = 0; a <= 9; a++) begin
      bus_read(8'(a * 4), rd);
      check("rst_read", rd, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    peek(8'h18, rd);
    check("rel_status", rd, 32'h0);
    check("rel_irq", {31'h0, gpio_irq}, 32'h0);

    // Output/direction registers and set/clear
    bus_write(8'h08, 32'h0000_00FF);
    bus_write(8'h1C, 32'h0000_000F);
    bus_write(8'h20, 32'h0000_0005);
    check("dir_pin", gpio_dir, 32'h0000_00FF);
    check("out_pin", gpio_out, 32'h0000_000A);
    bus_read(8'h04, rd); check("out_read", rd, 32'h0000_000A);
    bus_read(8'h08, rd); check("dir_read", rd, 32'h0000_00FF);
    bus_read(8'h07, rd); check("addr_lsb_ignored", rd, 32'h0000_000A);
    @(negedge clk); bus_valid = 1'b1; bus_addr = 8'h04; #1;
    check("ready_eq_valid", {31'h0, bus_ready}, 32'h1);
    bus_valid = 1'b0;
    bus_write(8'h04, 32'hA5A5_0F0F);
    bus_write(8'h1C, 32'h5000_0000);
    check("out_set2", gpio_out, 32'hF5A5_0F0F);
    bus_write(8'h20, 32'hA5A5_0000);
    bus_read(8'h04, rd); check("out_clr2", rd, 32'h5000_0F0F);
    bus_read(8'h1C, rd); check("wo_set_reads0", rd, 32'h0);
    bus_read(8'h20, rd); check("wo_clr_reads0", rd, 32'h0);
    bus_write(8'h30, 32'hFFFF_FFFF);
    bus_read(8'h30, rd); check("unmapped_read", rd, 32'h0);
    check("unmapped_write", gpio_out, 32'h5000_0F0F);
    bus_write(8'h24, 32'h0000_0003);
    bus_read(8'h24, rd); check("db_reg", rd, (DB_LAT == 1) ? 32'h3 : 32'h0);
    bus_write(8'h24, 32'h0000_0000);

    // Synchroniser depth: IN shows the pins only after two edges
    @(negedge clk); gpio_in = 32'h8000_0001;
    bus_read(8'h00, rd); check("in_1cyc", rd, 32'h0);
    bus_read(8'h00, rd); check("in_2cyc", rd, 32'h8000_0001);
    @(negedge clk); gpio_in = 32'h0;
    repeat (4) @(negedge clk);

    // All pins rising-edge, clear stale status, enable pin 8
    bus_write(8'h10, 32'hFFFF_FFFF);
    bus_write(8'h14, 32'hFFFF_FFFF);
    bus_write(8'h18, 32'hFFFF_FFFF);
    bus_read(8'h18, rd); check("status_cleared", rd, 32'h0);
    bus_write(8'h0C, 32'h0000_0100);
    check("irq_idle", {31'h0, gpio_irq}, 32'h0);

    // 100-cycle pulse on pin 8
    base_rises = irq_rises;
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (100) @(negedge clk);
    gpio_in[8] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8'h18, rd); check("edge_status", rd, 32'h0000_0100);
    check("edge_irq", {31'h0, gpio_irq}, 32'h1);
    check("irq_once", 32'(irq_rises - base_rises), 32'h1);
    bus_write(8'h18, 32'h0000_0100);
    @(negedge clk);
    check("w1c_irq", {31'h0, gpio_irq}, 32'h0);
    bus_read(8'h18, rd); check("w1c_status", rd, 32'h0);

    // W1C colliding with a fresh rising edge on pin 8
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (1 + DB_LAT) @(negedge clk);
    bus_write(8'h18, 32'h0000_0100);
    bus_read(8'h18, rd); check("edge_beats_w1c", rd, 32'h0000_0100);
    bus_write(8'h18, 32'h0000_0100);
    bus_read(8'h18, rd); check("plain_w1c", rd, 32'h0);
    @(negedge clk); gpio_in[8] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8'h18, rd); check("fall_ignored", rd, 32'h0);

    // Level-high on pin 3
    bus_write(8'h10, 32'hFFFF_FFF7);
    bus_read(8'h18, rd); check("level_low_pin", rd, 32'h0);
    @(negedge clk); gpio_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(8'h18, rd); check("level_set", rd, 32'h0000_0008);
    bus_read(8'h00, rd); check("in_pin3", rd, 32'h0000_0008);
    bus_write(8'h18, 32'h0000_0008);
    bus_read(8'h18, rd); check("level_w1c_now", rd, 32'h0000_0008);
    repeat (3) @(negedge clk);
    bus_read(8'h18, rd); check("level_w1c_later", rd, 32'h0000_0008);
    @(negedge clk); gpio_in[3] = 1'b0;
    repeat (2 + DB_LAT) @(negedge clk);
    bus_read(8'h18, rd); check("level_drop", rd, 32'h0);

`ifdef QAR_GPIO_DEBOUNCE_EN
    bus_write(8'h24, 32'h0000_000A);
    bus_read(8'h24, rd); check("db_limit", rd, 32'h0000_000A);
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[8] = 1'b0;
    repeat (25) @(negedge clk);
    bus_read(8'h18, rd); check("glitch_filtered", rd, 32'h0);
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (20) @(negedge clk);
    gpio_in[8] = 1'b0;
    repeat (25) @(negedge clk);
    bus_read(8'h18, rd); check("pulse_passes", rd, 32'h0000_0100);
`else
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[8] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8'h18, rd); check("glitch_unfiltered", rd, 32'h0000_0100);
`endif
    bus_write(8'h18, 32'h0000_0100);
    bus_read(8'h18, rd); check("final_w1c", rd, 32'h0);

    // Reset in the middle of a pending edge / debounce count
    @(negedge clk); gpio_in[8] = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0; gpio_in = 32'h0;
    #1;
    check("mid_rst_out", gpio_out, 32'h0);
    check("mid_rst_dir", gpio_dir, 32'h0);
    check("mid_rst_irq", {31'h0, gpio_irq}, 32'h0);
    for (int a = 0; a <= 9; a++) begin
      peek(8'(a * 4), rd);
      check("mid_rst_read", rd, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    peek(8'h18, rd);
    check("mid_rel_status", rd, 32'h0);
    check("mid_rel_irq", {31'h0, gpio_irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
